// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and LSU,
// with a registered write stage and a per-register busy scoreboard for decode.
module rf_wb_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int NREG       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [4:0]            alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [4:0]            lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   input  logic                  issue_valid,
   input  logic [4:0]            issue_rd,
   output logic                  issue_ready,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rf_wen,
   output logic [4:0]            rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);

   logic            last_lsu;
   logic [NREG-1:0] busy;
   logic            issue_set;

   // On contention the requester not served last wins
   always_comb begin
      alu_ready = alu_valid && (!lsu_valid || last_lsu);
      lsu_ready = lsu_valid && (!alu_valid || !last_lsu);
   end

   assign issue_ready = (issue_rd == 5'd0) || !busy[issue_rd];
   assign issue_set   = issue_valid && issue_ready && (issue_rd != 5'd0);
   assign rs1_busy    = (rs1 != 5'd0) && busy[rs1];
   assign rs2_busy    = (rs2 != 5'd0) && busy[rs2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_lsu <= 1'b0;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         if (alu_ready || lsu_ready)
            last_lsu <= lsu_ready;
         if (lsu_ready && lsu_rd != 5'd0) begin
            rf_wen   <= 1'b1;
            rf_waddr <= lsu_rd;
            rf_wdata <= lsu_data;
         end else if (alu_ready && alu_rd != 5'd0) begin
            rf_wen   <= 1'b1;
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
         end else begin
            rf_wen   <= 1'b0;
         end
      end
   end

   // A new producer issued on the retiring edge keeps the register busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy[0] <= 1'b0;
         for (int r = 1; r < NREG; r++) begin
            if (issue_set && issue_rd == 5'(r))
               busy[r] <= 1'b1;
            else if (rf_wen && rf_waddr == 5'(r))
               busy[r] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a
// cycle-level reference model of the arbitration/scoreboard rules.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [63:0] alu_data = '0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_rd = '0;
   logic [63:0] lsu_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        issue_ready;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;

   rf_wb_arbiter #(.DATA_WIDTH(64), .NREG(32)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_ready(issue_ready),
      .rs1(rs1), .rs2(rs2),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail = 0;

   // Reference state: who was served last, pending registers, write port
   bit        m_last_lsu;
   bit [31:0] m_busy;
   bit        m_wen;
   bit [4:0]  m_waddr;
   bit [63:0] m_wdata;
   bit        g_alu, g_lsu;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last_lsu = 1'b0;
      m_busy = '0;
      m_wen = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   // Call just after a negedge with inputs applied
   task automatic cycle();
      bit ga, gl, ir;
      bit [31:0] nb;
      #1;
      if (alu_valid && lsu_valid) begin
         ga = m_last_lsu;
         gl = !m_last_lsu;
      end else begin
         ga = alu_valid;
         gl = lsu_valid;
      end
      ir = (issue_rd == 0) || !m_busy[issue_rd];
      chk("alu_ready", alu_ready, ga);
      chk("lsu_ready", lsu_ready, gl);
      chk("issue_ready", issue_ready, ir);
      chk("rs1_busy", rs1_busy, m_busy[rs1]);
      chk("rs2_busy", rs2_busy, m_busy[rs2]);
      g_alu = ga;
      g_lsu = gl;
      @(posedge clk);
      nb = m_busy;
      if (m_wen) nb[m_waddr] = 1'b0;
      if (issue_valid && ir && issue_rd != 0) nb[issue_rd] = 1'b1;
      m_busy = nb;
      if (ga || gl) m_last_lsu = gl;
      m_wen = 1'b0;
      if (gl && lsu_rd != 0) begin
         m_wen = 1'b1; m_waddr = lsu_rd; m_wdata = lsu_data;
      end
      if (ga && alu_rd != 0) begin
         m_wen = 1'b1; m_waddr = alu_rd; m_wdata = alu_data;
      end
      #1;
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      @(negedge clk);
   endtask

   task automatic idle();
      alu_valid = 0; lsu_valid = 0; issue_valid = 0;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_wen", rf_wen, 1'b0);
      chk("rst_waddr", rf_waddr, 5'd0);
      chk("rst_wdata", rf_wdata, 64'd0);
      chk("rst_rs1_busy", rs1_busy, 1'b0);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      rs1 = 5; rs2 = 3;
      reset_pulse();

      // Reset mid-stream: write to 5 accepted, reset lands before its edge
      issue_valid = 1; issue_rd = 5;
      cycle();
      idle();
      alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
      cycle();
      idle();
      chk("t1_wen_pending", rf_wen, 1'b1);
      reset_pulse();
      chk("t1_busy5", rs1_busy, 1'b0);
      alu_valid = 1; alu_rd = 9; lsu_valid = 1; lsu_rd = 10;
      #1;
      chk("t1_lsu_first", lsu_ready, 1'b1);
      chk("t1_alu_wait", alu_ready, 1'b0);
      cycle();
      cycle();
      idle();
      cycle();

      // Single ALU writeback with scoreboard clear
      rs1 = 3;
      issue_valid = 1; issue_rd = 3;
      cycle();
      idle();
      chk("t2_busy_set", rs1_busy, 1'b1);
      alu_valid = 1; alu_rd = 3; alu_data = 64'hDEAD;
      cycle();
      idle();
      chk("t2_wdata", rf_wdata, 64'hDEAD);
      chk("t2_still_busy", rs1_busy, 1'b1);
      cycle();
      chk("t2_busy_clr", rs1_busy, 1'b0);

      // Contention: grants alternate LSU, ALU, LSU, ALU
      lsu_valid = 1; lsu_rd = 1; lsu_data = 64'h11;
      alu_valid = 1; alu_rd = 2; alu_data = 64'h22;
      #1 chk("t3_g0_lsu", lsu_ready, 1'b1);
      cycle();
      lsu_rd = 3; lsu_data = 64'h33;
      #1 chk("t3_g1_alu", alu_ready, 1'b1);
      cycle();
      chk("t3_w1", rf_waddr, 5'd2);
      alu_rd = 4; alu_data = 64'h44;
      #1 chk("t3_g2_lsu", lsu_ready, 1'b1);
      cycle();
      chk("t3_w2", rf_waddr, 5'd3);
      lsu_valid = 0;
      cycle();
      chk("t3_w3", rf_waddr, 5'd4);
      idle();
      cycle();

      // x0 handling
      lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hFFFF;
      issue_valid = 1; issue_rd = 0; rs1 = 0; rs2 = 0;
      #1;
      chk("t4_lsu_ready", lsu_ready, 1'b1);
      chk("t4_issue_ready", issue_ready, 1'b1);
      cycle();
      idle();
      chk("t4_no_wen", rf_wen, 1'b0);
      chk("t4_x0_busy", rs1_busy, 1'b0);

      // WAW: issue of 7 stalls while 7 is busy, even on its retiring edge
      rs1 = 7;
      issue_valid = 1; issue_rd = 7;
      cycle();
      idle();
      alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
      issue_valid = 1; issue_rd = 7;
      #1 chk("t5_stall_a", issue_ready, 1'b0);
      cycle();
      alu_valid = 0;
      #1 chk("t5_stall_b", issue_ready, 1'b0);
      cycle();
      cycle();
      idle();
      chk("t5_reissued", rs1_busy, 1'b1);
      alu_valid = 1; alu_rd = 7;
      cycle();
      idle();
      cycle();

      // Randomized traffic, requesters hold fields while stalled
      g_alu = 1; g_lsu = 1;
      for (int i = 0; i < 400; i++) begin
         if (!(alu_valid && !g_alu)) begin
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd = 5'($urandom_range(0, 31));
            alu_data = {$urandom, $urandom};
         end
         if (!(lsu_valid && !g_lsu)) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_rd = 5'($urandom_range(0, 31));
            lsu_data = {$urandom, $urandom};
         end
         issue_valid = $urandom_range(0, 1) == 1;
         issue_rd = 5'($urandom_range(0, 31));
         rs1 = 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
